// File: rtl/icache_refill.sv
// Instruction cache line refill: arbitrates for RAM, streams one byte per
// cycle into a block buffer and presents the finished line for one cycle.
module icache_refill #(
    parameter int BLOCK_WIDTH = 4,
    parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
    input  logic                      clkIn,
    input  logic                      resetIn,
    input  logic                      readyIn,
    input  logic                      flushIn,
    input  logic                      missIn,
    input  logic [31:0]               missAddrIn,
    input  logic                      ramGrantIn,
    input  logic [7:0]                ramDataIn,
    output logic                      ramReqOut,
    output logic [31:0]               ramAddrOut,
    output logic                      memDataValid,
    output logic [31:BLOCK_WIDTH]     memAddr,
    output logic [BLOCK_SIZE*8-1:0]   memDataOut,
    output logic                      busyOut
);

    localparam int CW = BLOCK_WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(BLOCK_SIZE);

    typedef enum logic [1:0] {IDLE, REQ, FETCH, DONE} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [31-BLOCK_WIDTH:0]   r_base;
    logic [31-BLOCK_WIDTH:0]   r_memAddr;
    logic [CW-1:0]             r_issue;
    logic [CW-1:0]             r_cap;
    logic [BLOCK_SIZE*8-1:0]   r_buf;
    logic [BLOCK_SIZE*8-1:0]   r_memData;
    logic [BLOCK_SIZE*8-1:0]   w_block;
    logic                      w_issue;
    logic                      w_capture;
    logic                      w_last;

    // Capture trails issue by one cycle; the two counters differ while
    // a RAM byte is in flight.
    assign w_issue   = (r_state == FETCH) && (r_issue != LAST);
    assign w_capture = (r_state == FETCH) && (r_cap != r_issue);
    assign w_last    = (r_state == FETCH) && (r_issue == LAST);

    assign ramReqOut    = (r_state == REQ) || (r_state == FETCH);
    assign busyOut      = (r_state != IDLE);
    assign memDataValid = (r_state == DONE);
    assign memAddr      = r_memAddr;
    assign memDataOut   = r_memData;
    assign ramAddrOut   = w_issue ? {r_base, r_issue[BLOCK_WIDTH-1:0]} : 32'd0;

    always_comb begin
        w_block = r_buf;
        w_block[{r_cap[BLOCK_WIDTH-1:0], 3'b000} +: 8] = ramDataIn;
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flushIn) begin
            w_next = IDLE;
        end else if (readyIn) begin
            case (r_state)
                IDLE:    if (missIn) w_next = REQ;
                REQ:     if (ramGrantIn) w_next = FETCH;
                FETCH:   if (w_last) w_next = DONE;
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            r_base    <= '0;
            r_issue   <= '0;
            r_cap     <= '0;
            r_buf     <= '0;
            r_memAddr <= '0;
            r_memData <= '0;
        end else if (flushIn) begin
            r_issue <= '0;
            r_cap   <= '0;
        end else if (readyIn) begin
            if (r_state == IDLE && missIn) r_base <= missAddrIn[31:BLOCK_WIDTH];
            if (r_state == REQ) begin
                r_issue <= '0;
                r_cap   <= '0;
            end
            if (w_issue) r_issue <= r_issue + 1'b1;
            if (w_capture) begin
                r_buf <= w_block;
                r_cap <= r_cap + 1'b1;
            end
            if (w_last) begin
                r_memAddr <= r_base;
                r_memData <= w_block;
            end
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: directed scenarios plus random
// traffic, all outputs compared each cycle against a behavioural model.
module tb_icache_refill;

    logic         clk = 0;
    logic         rst, ready, flush, miss, grant;
    logic [31:0]  missAddr;
    logic [7:0]   ramData;
    logic         ramReq, valid, busy;
    logic [31:0]  ramAddr;
    logic [31:4]  memAddr;
    logic [127:0] memData;

    icache_refill dut (
        .clkIn(clk), .resetIn(rst), .readyIn(ready), .flushIn(flush),
        .missIn(miss), .missAddrIn(missAddr), .ramGrantIn(grant),
        .ramDataIn(ramData), .ramReqOut(ramReq), .ramAddrOut(ramAddr),
        .memDataValid(valid), .memAddr(memAddr), .memDataOut(memData),
        .busyOut(busy)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int c0 = 0;
    int gdelay = 0;
    int gcnt = 0;
    bit chk_on = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s act=%h exp=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] f(logic [31:0] a);
        return (a[7:0] - 8'h20) ^ a[23:16];
    endfunction

    function automatic logic [127:0] blk(logic [27:0] b);
        logic [127:0] d;
        for (int k = 0; k < 16; k++) d[8*k +: 8] = f({b, 4'(k)});
        return d;
    endfunction

    // RAM: registered read, stalls with the global ready
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ready) ramData <= f(ramAddr);
    end

    // Arbiter: grants after gdelay ready cycles of request, holds while requested
    always @(negedge clk) begin
        if (!ramReq) begin
            gcnt = 0;
            grant = 0;
        end else if (ready && !grant) begin
            if (gcnt >= gdelay) grant = 1;
            else gcnt++;
        end
    end

    // Behavioural model: 0 idle, 1 awaiting grant, 2 fetching (p ready cycles in), 3 done
    int           md = 0;
    int           mp = 0;
    logic [27:0]  mbase = 0;
    logic [27:0]  mA = 0;
    logic [127:0] mD = 0;

    always @(posedge clk) begin
        if (rst) begin
            md = 0; mp = 0; mA = 0; mD = 0;
        end else if (flush) begin
            md = 0;
        end else if (ready) begin
            case (md)
                0: if (miss) begin mbase = missAddr[31:4]; md = 1; end
                1: if (grant) begin md = 2; mp = 0; end
                2: if (mp == 16) begin md = 3; mA = mbase; mD = blk(mbase); end
                   else mp++;
                default: md = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", busy, md != 0);
            chk("ramReq", ramReq, md == 1 || md == 2);
            chk("valid", valid, md == 3);
            chk("ramAddr", ramAddr,
                (md == 2 && mp < 16) ? {mbase, 4'(mp)} : 32'd0);
            chk("memAddr", memAddr, mA);
            chk("memData", memData, mD);
        end
    end

    task automatic start_miss(logic [31:0] a);
        @(posedge clk); #1;
        miss = 1; missAddr = a; c0 = cyc + 1;
        @(posedge clk); #1;
        miss = 0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (valid) begin
                lat = cyc - c0 + 1;
                break;
            end
        end
        if (lat < 0) chk("valid_timeout", 0, 1);
    endtask

    task automatic wait_byte(int k);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ramReq && ramAddr != 0 && ramAddr[3:0] == 4'(k)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("addr_timeout", 0, 1);
    endtask

    task automatic count_pulses(int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid) c++;
        end
    endtask

    int lat, np;

    initial begin
        rst = 1; ready = 1; flush = 0; miss = 0; missAddr = 0; grant = 0;
        ramData = 0;
        @(posedge clk); #1;
        chk_on = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_data", memData, 0);

        // basic refill
        start_miss(32'h0000_1234);
        wait_valid(lat);
        chk("basic_lat", lat, 19);
        chk("basic_addr", memAddr, 28'h123);
        chk("basic_data", memData, 128'h1F1E1D1C1B1A19181716151413121110);
        count_pulses(5, np);
        chk("basic_one_pulse", np, 0);

        // grant withheld five cycles
        gdelay = 5;
        start_miss(32'h0000_4560);
        wait_valid(lat);
        chk("grant_lat", lat, 24);
        gdelay = 0;

        // three-cycle stall at byte 7
        start_miss(32'h0000_7770);
        wait_byte(7);
        ready = 0;
        repeat (3) @(posedge clk);
        #1 ready = 1;
        wait_valid(lat);
        chk("stall_lat", lat, 22);
        chk("stall_data", memData, blk(28'h777));

        // flush at byte 9, then a clean refill
        start_miss(32'h0000_8880);
        wait_byte(9);
        flush = 1;
        @(posedge clk); #1 flush = 0;
        @(negedge clk);
        chk("flush_busy", busy, 0);
        chk("flush_req", ramReq, 0);
        count_pulses(20, np);
        chk("flush_no_pulse", np, 0);
        start_miss(32'h0000_2000);
        wait_valid(lat);
        chk("after_flush_lat", lat, 19);
        chk("after_flush_addr", memAddr, 28'h200);

        // reset at byte 4
        start_miss(32'h0000_9990);
        wait_byte(4);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_outs", {ramReq, valid, busy, ramAddr}, 0);
        chk("rst_addr", memAddr, 0);
        chk("rst_data", memData, 0);
        count_pulses(20, np);
        chk("rst_no_pulse", np, 0);

        // miss address changes mid-fetch are ignored
        start_miss(32'h0000_ABC0);
        wait_byte(2);
        miss = 1; missAddr = 32'h0000_5000;
        wait_byte(10);
        miss = 0;
        wait_valid(lat);
        chk("ignore_addr", memAddr, 28'hABC);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            ready    = ($urandom % 10) != 0;
            flush    = ($urandom % 60) == 0;
            rst      = ($urandom % 500) == 0;
            miss     = ($urandom % 4) == 0;
            missAddr = $urandom;
            if (i % 50 == 0) gdelay = $urandom_range(0, 3);
        end
        @(posedge clk); #1;
        ready = 1; flush = 0; rst = 0; miss = 0;
        repeat (40) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 SHALL have parameter BLOCK_WIDTH, default 4, log2 of cache block size in bytes.
REQ-002 SHALL have parameter BLOCK_SIZE, default 2**BLOCK_WIDTH, block size in bytes.
REQ-003 clkIn  input  1  sole clock, all state on rising edge.
REQ-004 resetIn  input  1  synchronous, active-high reset.
REQ-005 readyIn  input  1  global ready; 0 freezes block.
REQ-006 flushIn  input  1  abort any refill in progress.
REQ-007 missIn  input  1  instruction cache miss request.
REQ-008 missAddrIn  input  32  address that missed.
REQ-009 ramGrantIn  input  1  memory arbiter grant.
REQ-010 ramDataIn  input  8  RAM read byte; 1-cycle latency after address.
REQ-011 ramReqOut  output  1  RAM access request to arbiter.
REQ-012 ramAddrOut  output  32  RAM byte read address.
REQ-013 memDataValid  output  1  one-cycle strobe; refilled block ready for cache write.
REQ-014 memAddr  output  [31:BLOCK_WIDTH]  block address of refilled line.
REQ-015 memDataOut  output  BLOCK_SIZE*8  refilled block, little-endian.
REQ-016 busyOut  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, REQ, FETCH, DONE.
REQ-018 IDLE: missIn=1 -> latch missAddrIn[31:BLOCK_WIDTH] as block base; go REQ.
REQ-019 REQ: ramReqOut=1; ramGrantIn=1 -> FETCH next cycle, else stay.
REQ-020 ramReqOut SHALL be 1 in REQ and FETCH, 0 in IDLE and DONE.
REQ-021 ramGrantIn SHALL be sampled only in REQ; grant is held by the arbiter while ramReqOut=1.
REQ-022 FETCH: issue counter 0..BLOCK_SIZE-1 drives ramAddrOut = {base, issueCnt}, one byte per cycle.
REQ-023 Byte issued in cycle t SHALL be captured from ramDataIn in cycle t+1 into memDataOut[8k+7:8k], k = byte offset.
REQ-024 FETCH SHALL last BLOCK_SIZE+1 cycles, then DONE.
REQ-025 DONE: memDataValid=1 for exactly one cycle, memAddr = base, memDataOut = full block; next state IDLE.
REQ-026 Zero-stall latency, default parameters: missIn sampled cycle 0, grant in cycle 1, memDataValid in cycle 19.
REQ-027 ramAddrOut SHALL be 0 when no byte is being issued.
REQ-028 missIn and missAddrIn SHALL be ignored outside IDLE; a miss still high on return to IDLE starts a new refill.
REQ-029 readyIn=0 SHALL freeze state, counters, captures and all outputs; no byte captured; resume exactly where stopped.
REQ-030 flushIn=1 in any state SHALL return to IDLE next cycle, regardless of readyIn.
REQ-031 After a flush: ramReqOut=0, memDataValid not pulsed for the aborted block; partial memDataOut contents are don't-care.
REQ-032 Priority: resetIn > flushIn > readyIn=0 > normal operation.
REQ-033 memAddr and memDataOut SHALL hold their last values outside DONE.

Reset
REQ-034 resetIn=1 at a clock edge SHALL force IDLE and zero both counters.
REQ-035 Reset SHALL clear ramReqOut, memDataValid, busyOut, ramAddrOut, memAddr and memDataOut to 0.
REQ-036 Reset mid-refill SHALL abort it without a memDataValid pulse; missIn is not sampled in the reset cycle.

Verification
REQ-037 Basic refill, no stalls: missIn=1, missAddrIn=0x0000_1234, grant in cycle 1, RAM byte k = 0x10+k -> reads 0x1230..0x123F; memDataValid cycle 19; memAddr=0x123; memDataOut=0x1F1E..1110; one pulse only.
REQ-038 Grant delay: grant withheld 5 cycles -> ramReqOut high throughout; memDataValid 5 cycles later (cycle 24).
REQ-039 Stall: readyIn=0 for 3 cycles mid-FETCH at byte 7 -> ramAddrOut held; data still correct; memDataValid delayed exactly 3 cycles.
REQ-040 Flush at byte 9 -> IDLE next cycle; ramReqOut=0; no memDataValid; following miss at 0x2000 refills correctly.
REQ-041 Reset at byte 4 -> all outputs 0 next cycle; no memDataValid.
REQ-042 Miss changes during FETCH: missAddrIn changed to 0x5000 -> ignored; memAddr = original block.
